// File: rtl/regex_cpu_multi_op_pipelined.sv
// Character-consuming regex execution unit: fetches one instruction per thread,
// executes it against the thread's character context and queues survivors in a FWFT FIFO.
package instruction_package;
  localparam logic [2:0] ACCEPT                = 3'd0;
  localparam logic [2:0] SPLIT                 = 3'd1;
  localparam logic [2:0] MATCH                 = 3'd2;
  localparam logic [2:0] JMP                   = 3'd3;
  localparam logic [2:0] END_WITHOUT_ACCEPTING = 3'd4;
  localparam logic [2:0] MATCH_ANY             = 3'd5;
  localparam logic [2:0] ACCEPT_PARTIAL        = 3'd6;
  localparam logic [2:0] NOT_MATCH             = 3'd7;
endpackage

module regex_cpu_multi_op_pipelined #(
  parameter int unsigned PC_WIDTH              = 9,
  parameter int unsigned CHARACTER_WIDTH       = 8,
  parameter int unsigned MEMORY_WIDTH          = 16,
  parameter int unsigned MEMORY_ADDR_WIDTH     = 11,
  parameter int unsigned FIFO_WIDTH_POWER_OF_2 = 2,
  parameter int unsigned CC_ID_BITS            = 2
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic [(2**CC_ID_BITS)*CHARACTER_WIDTH-1:0]  current_characters,
  input  logic [(2**CC_ID_BITS)-1:0]                  end_of_string,
  input  logic                                        input_pc_valid,
  input  logic [CC_ID_BITS-1:0]                       input_cc_id,
  input  logic [PC_WIDTH-1:0]                         input_pc,
  output logic                                        input_pc_ready,
  output logic                                        memory_valid,
  output logic [MEMORY_ADDR_WIDTH-1:0]                memory_addr,
  input  logic                                        memory_ready,
  input  logic [MEMORY_WIDTH-1:0]                     memory_data,
  output logic                                        output_pc_valid,
  output logic [PC_WIDTH-1:0]                         output_pc,
  output logic [CC_ID_BITS-1:0]                       output_cc_id,
  input  logic                                        output_pc_ready,
  output logic                                        accepts,
  output logic                                        running,
  output logic [(2**CC_ID_BITS)-1:0]                  elaborating_chars
);
  localparam int unsigned N_CC  = 1 << CC_ID_BITS;
  localparam int unsigned DEPTH = 1 << FIFO_WIDTH_POWER_OF_2;
  localparam int unsigned PTR_W = FIFO_WIDTH_POWER_OF_2;
  localparam int unsigned CNT_W = FIFO_WIDTH_POWER_OF_2 + 1;
  // Admission needs two free slots so a SPLIT can always push both threads.
  localparam logic [CNT_W-1:0] ADMIT_MAX = CNT_W'(DEPTH - 2);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_EXEC  = 2'd3;

  logic [1:0]              state_q, state_d;
  logic [PC_WIDTH-1:0]     pc_q, pc_d;
  logic [CC_ID_BITS-1:0]   cc_q, cc_d;
  logic [MEMORY_WIDTH-1:0] instr_q, instr_d;
  logic                    accepts_q, accepts_d;

  logic [PC_WIDTH-1:0]     fifo_pc_q [DEPTH];
  logic [CC_ID_BITS-1:0]   fifo_cc_q [DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]        count_q, count_d;

  logic [CHARACTER_WIDTH-1:0] chars [N_CC];
  logic [CHARACTER_WIDTH-1:0] cur_char;
  logic [CHARACTER_WIDTH-1:0] ch;
  logic                       cur_eos;
  logic [2:0]                 opcode;
  logic [PC_WIDTH-1:0]        nxt, tgt;
  logic [CC_ID_BITS-1:0]      cc_inc;
  logic                       push0, push1, pop, exec_accept;
  logic [PC_WIDTH-1:0]        push0_pc, push1_pc;
  logic [CC_ID_BITS-1:0]      push0_cc, push1_cc;
  logic                       fifo_empty;
  logic                       unused_instr;

  always_comb begin
    for (int unsigned k = 0; k < N_CC; k++) begin
      chars[k] = current_characters[k*CHARACTER_WIDTH +: CHARACTER_WIDTH];
    end
  end

  assign cur_char     = chars[cc_q];
  assign cur_eos      = end_of_string[cc_q];
  assign opcode       = instr_q[MEMORY_WIDTH-1 -: 3];
  assign ch           = instr_q[CHARACTER_WIDTH-1:0];
  assign tgt          = instr_q[PC_WIDTH-1:0];
  assign nxt          = pc_q + PC_WIDTH'(1);
  assign cc_inc       = cc_q + CC_ID_BITS'(1);
  assign unused_instr = ^instr_q;

  assign fifo_empty      = (count_q == '0);
  assign input_pc_ready  = (state_q == S_IDLE) && (count_q <= ADMIT_MAX);
  assign memory_valid    = (state_q == S_FETCH);
  assign memory_addr     = MEMORY_ADDR_WIDTH'(pc_q);
  assign output_pc_valid = !fifo_empty;
  assign output_pc       = fifo_pc_q[rd_ptr_q];
  assign output_cc_id    = fifo_cc_q[rd_ptr_q];
  assign pop             = !fifo_empty && output_pc_ready;
  assign accepts         = accepts_q;
  assign running         = (state_q != S_IDLE) || !fifo_empty;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cc_d    = cc_q;
    instr_d = instr_q;
    case (state_q)
      S_IDLE: begin
        if (input_pc_valid && input_pc_ready) begin
          pc_d    = input_pc;
          cc_d    = input_cc_id;
          state_d = S_FETCH;
        end
      end
      S_FETCH: if (memory_ready) state_d = S_WAIT;
      S_WAIT: begin
        instr_d = memory_data;
        state_d = S_EXEC;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    push0       = 1'b0;
    push1       = 1'b0;
    push0_pc    = nxt;
    push0_cc    = cc_inc;
    push1_pc    = tgt;
    push1_cc    = cc_q;
    exec_accept = 1'b0;
    if (state_q == S_EXEC) begin
      case (opcode)
        instruction_package::MATCH:          push0 = !cur_eos && (cur_char == ch);
        instruction_package::NOT_MATCH:      push0 = !cur_eos && (cur_char != ch);
        instruction_package::MATCH_ANY:      push0 = !cur_eos;
        instruction_package::JMP: begin
          push0    = 1'b1;
          push0_pc = tgt;
          push0_cc = cc_q;
        end
        instruction_package::SPLIT: begin
          push0    = 1'b1;
          push0_cc = cc_q;
          push1    = 1'b1;
        end
        instruction_package::ACCEPT:         exec_accept = cur_eos;
        instruction_package::ACCEPT_PARTIAL: exec_accept = 1'b1;
        default: ;
      endcase
    end
  end

  assign accepts_d = exec_accept;
  assign wr_ptr_d  = wr_ptr_q + PTR_W'(push0) + PTR_W'(push1);
  assign rd_ptr_d  = rd_ptr_q + PTR_W'(pop);
  assign count_d   = count_q + CNT_W'(push0) + CNT_W'(push1) - CNT_W'(pop);

  always_comb begin
    logic [PTR_W-1:0] off;
    elaborating_chars = '0;
    if (state_q != S_IDLE) elaborating_chars[cc_q] = 1'b1;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      off = PTR_W'(i) - rd_ptr_q;
      if (CNT_W'(off) < count_q) elaborating_chars[fifo_cc_q[i]] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      cc_q      <= '0;
      instr_q   <= '0;
      accepts_q <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      cc_q      <= cc_d;
      instr_q   <= instr_d;
      accepts_q <= accepts_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  // SPLIT writes the fall-through pc first so it reaches the head first.
  always_ff @(posedge clk) begin
    if (push0) begin
      fifo_pc_q[wr_ptr_q] <= push0_pc;
      fifo_cc_q[wr_ptr_q] <= push0_cc;
    end
    if (push1) begin
      fifo_pc_q[wr_ptr_q + PTR_W'(1)] <= push1_pc;
      fifo_cc_q[wr_ptr_q + PTR_W'(1)] <= push1_cc;
    end
  end
endmodule
